mem_initiator: RTL and testbench
================================

Name: mem_initiator

Overview:
- Initiator-side controller for the team's single-port synchronous word memory (1-cycle registered read, write-priority, synchronous read-data clear).
- Turns burst commands from a test/DMA client into memory cycles.
- Write beats stream in on a data channel; read beats stream out on a response channel with backpressure.
- Sits between the client and the memory, and owns all of the memory's input pins.

Parameters:
- ADDR_W, 16, memory address width.
- DATA_W, 32, word width.
- DEPTH, 1024, memory words; must be a power of two.
- LEN_W, 8, burst length field width; beats = cmd_len_i + 1.

Ports:
- clk_i  in  1  clock, rising edge.
- arst_ni  in  1  asynchronous active-low reset.
- cmd_valid_i  in  1  command valid.
- cmd_ready_o  out  1  command accepted when both valid and ready are high.
- cmd_we_i  in  1  1 = write burst, 0 = read burst.
- cmd_addr_i  in  ADDR_W  start word address.
- cmd_len_i  in  LEN_W  beats minus one.
- wd_valid_i  in  1  write data valid.
- wd_ready_o  out  1  write data ready.
- wd_data_i  in  DATA_W  write data.
- rd_valid_o  out  1  read data valid.
- rd_ready_i  in  1  read data ready.
- rd_data_o  out  DATA_W  read data.
- rd_last_o  out  1  final beat of a read burst.
- done_o  out  1  one-cycle pulse when a burst completes.
- err_o  out  1  one-cycle error pulse; driven only under the optional feature, otherwise tied 0.
- mem_we_o  out  1  to memory write enable.
- mem_srst_o  out  1  to memory read-data clear.
- mem_addr_o  out  ADDR_W  to memory address.
- mem_wdata_o  out  DATA_W  to memory write data.
- mem_rdata_i  in  DATA_W  from memory read data.

Behaviour:
- Reset (arst_ni low, at any time, including mid-burst): state goes to IDLE immediately.
  - rd_valid_o, rd_last_o, done_o, err_o, mem_we_o = 0.
  - rd_data_o, mem_addr_o, mem_wdata_o = 0.
  - mem_srst_o = 1; cmd_ready_o = 1.
  - An in-flight burst is abandoned; no resume.
- FSM states: IDLE, WR, RD_ISSUE, RD_CAPT, RD_RESP.
- IDLE:
  - cmd_ready_o = 1 and mem_srst_o = 1; all other handshake outputs are 0.
  - On a command handshake, latch the address (low log2(DEPTH) bits, upper bits forced 0) and the beat counter.
  - Go to WR if cmd_we_i = 1, else to RD_ISSUE.
- WR:
  - wd_ready_o = 1.
  - mem_we_o = wd_valid_i; mem_wdata_o = wd_data_i; mem_addr_o = current address. All three are combinational.
  - On each wd handshake, the address increments and the counter decrements.
  - On the last beat, go to IDLE; done_o pulses on the next cycle.
  - While wd_valid_i is low: no write, and the address holds.
- RD_ISSUE: mem_addr_o = address, mem_we_o = 0, mem_srst_o = 0. Go to RD_CAPT.
- RD_CAPT: mem_rdata_i is valid this cycle. Register it into rd_data_o, set rd_valid_o, and set rd_last_o if counter = 0. Go to RD_RESP.
- RD_RESP:
  - rd_valid_o, rd_data_o and rd_last_o hold stable until rd_ready_i = 1.
  - On that handshake, clear rd_valid_o.
  - If last: go to IDLE and pulse done_o on the next cycle.
  - Otherwise: increment the address and go to RD_ISSUE.
- Read latency: rd_valid_o rises 2 cycles after RD_ISSUE is entered. Maximum throughput is one beat per 3 cycles.
- Address wrap: next address = (addr == DEPTH-1) ? 0 : addr + 1.
- cmd_ready_o is low in all states other than IDLE. A command presented while busy is held off, not dropped.
- mem_we_o and mem_srst_o are never high in the same cycle.

Optional Feature:
- Macro: MEM_INITIATOR_RANGE_CHECK_EN.
- Defined: at command handshake, if cmd_addr_i >= DEPTH or cmd_addr_i + cmd_len_i >= DEPTH, the command is rejected.
  - err_o pulses for 1 cycle.
  - No memory access occurs; the block stays in IDLE with cmd_ready_o = 1 and no done_o.
- Undefined: no check; the address is truncated and wraps as described above. err_o is tied 0.

Test Plan:
- Reset mid-burst: assert arst_ni low during RD_RESP of a 4-beat read -> outputs take their reset values at once (rd_valid_o = 0, mem_srst_o = 1); after release, cmd_ready_o = 1 and a new read works.
- Single write then read: write 0x005 / 0xDEADBEEF (len 0), then read 0x005 -> rd_data_o = 0xDEADBEEF with rd_last_o = 1; done_o pulses once per burst.
- Wrap (macro undefined): write 0x3FE, len 3, data 1,2,3,4 -> memory writes land at 0x3FE, 0x3FF, 0x000, 0x001; reading 0x3FE, len 3 returns 1,2,3,4 with rd_last_o on beat 4 only.
- Read backpressure: hold rd_ready_i low for 5 cycles per beat -> rd_data_o stays stable, no skipped or repeated beats, mem_addr_o does not advance.
- Write stalls: drop wd_valid_i for 3 cycles between beats -> mem_we_o = 0 during the gap and no address advance; readback matches.
- Macro defined: command addr 0x3FE, len 3 -> err_o = 1 for one cycle, mem_we_o never asserted, no done_o; a following valid command is accepted normally.

Source files
------------

// File: rtl/mem_initiator.sv
// Burst initiator for the single-port synchronous word memory: streams write beats in and read beats out.
// Optional command range check: define MEM_INITIATOR_RANGE_CHECK_EN.
module mem_initiator #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 1024,
    parameter int LEN_W  = 8
) (
    input  logic              clk_i,
    input  logic              arst_ni,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic              cmd_we_i,
    input  logic [ADDR_W-1:0] cmd_addr_i,
    input  logic [LEN_W-1:0]  cmd_len_i,
    input  logic              wd_valid_i,
    output logic              wd_ready_o,
    input  logic [DATA_W-1:0] wd_data_i,
    output logic              rd_valid_o,
    input  logic              rd_ready_i,
    output logic [DATA_W-1:0] rd_data_o,
    output logic              rd_last_o,
    output logic              done_o,
    output logic              err_o,
    output logic              mem_we_o,
    output logic              mem_srst_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic [2:0]        state_o
);

    localparam int IDX_W = $clog2(DEPTH);

    // All channels use valid/ready: a beat or command transfers on a rising clk_i edge where
    // both are high; a source holds its payload stable while valid is high and ready is low.

    typedef enum logic [2:0] {IDLE, WR, RD_ISSUE, RD_CAPT, RD_RESP} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_nxt;
    logic [LEN_W-1:0]  cnt_q;
    logic [DATA_W-1:0] rd_data_q;
    logic              rd_valid_q, rd_last_q, done_q;
    logic              cmd_bad;

    assign addr_nxt = (addr_q == ADDR_W'(DEPTH - 1)) ? '0 : addr_q + ADDR_W'(1);

`ifdef MEM_INITIATOR_RANGE_CHECK_EN
    logic [ADDR_W:0] end_addr;
    logic            err_q;

    assign end_addr = {1'b0, cmd_addr_i} + (ADDR_W + 1)'(cmd_len_i);
    assign cmd_bad  = ({1'b0, cmd_addr_i} >= (ADDR_W + 1)'(DEPTH)) ||
                      (end_addr >= (ADDR_W + 1)'(DEPTH));
    assign err_o    = err_q;

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) err_q <= 1'b0;
        else          err_q <= (state_q == IDLE) && cmd_valid_i && cmd_bad;
    end
`else
    logic unused_addr_hi;

    // Without the check, upper address bits are simply discarded.
    assign unused_addr_hi = ^cmd_addr_i[ADDR_W-1:IDX_W];
    assign cmd_bad        = 1'b0;
    assign err_o          = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d     = state_q;
        cmd_ready_o = 1'b0;
        wd_ready_o  = 1'b0;
        mem_we_o    = 1'b0;
        mem_srst_o  = 1'b1;
        mem_wdata_o = '0;
        case (state_q)
            IDLE: begin
                cmd_ready_o = 1'b1;
                if (cmd_valid_i && !cmd_bad) state_d = cmd_we_i ? WR : RD_ISSUE;
            end
            WR: begin
                wd_ready_o  = 1'b1;
                mem_srst_o  = 1'b0;
                mem_we_o    = wd_valid_i;
                mem_wdata_o = wd_data_i;
                if (wd_valid_i && cnt_q == '0) state_d = IDLE;
            end
            RD_ISSUE: begin
                mem_srst_o = 1'b0;
                state_d    = RD_CAPT;
            end
            RD_CAPT: state_d = RD_RESP;
            RD_RESP: begin
                if (rd_ready_i) state_d = rd_last_q ? IDLE : RD_ISSUE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            addr_q     <= '0;
            cnt_q      <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            rd_last_q  <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (cmd_valid_i && !cmd_bad) begin
                        addr_q <= ADDR_W'(cmd_addr_i[IDX_W-1:0]);
                        cnt_q  <= cmd_len_i;
                    end
                end
                WR: begin
                    if (wd_valid_i) begin
                        addr_q <= addr_nxt;
                        cnt_q  <= cnt_q - LEN_W'(1);
                        if (cnt_q == '0) done_q <= 1'b1;
                    end
                end
                RD_CAPT: begin
                    rd_data_q  <= mem_rdata_i;
                    rd_valid_q <= 1'b1;
                    rd_last_q  <= (cnt_q == '0);
                end
                RD_RESP: begin
                    if (rd_ready_i) begin
                        rd_valid_q <= 1'b0;
                        rd_last_q  <= 1'b0;
                        if (rd_last_q) begin
                            done_q <= 1'b1;
                        end else begin
                            addr_q <= addr_nxt;
                            cnt_q  <= cnt_q - LEN_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign mem_addr_o = addr_q;
    assign rd_data_o  = rd_data_q;
    assign rd_valid_o = rd_valid_q;
    assign rd_last_o  = rd_last_q;
    assign done_o     = done_q;
    assign state_o    = state_q;

endmodule

// File: tb/tb_mem_initiator.sv
// Directed bench for mem_initiator with a behavioural memory and a queue-based scoreboard.
module tb_mem_initiator;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 1024;
    localparam int LEN_W  = 8;

    logic              clk_i = 1'b0;
    logic              arst_ni;
    logic              cmd_valid_i, cmd_ready_o, cmd_we_i;
    logic [ADDR_W-1:0] cmd_addr_i;
    logic [LEN_W-1:0]  cmd_len_i;
    logic              wd_valid_i, wd_ready_o;
    logic [DATA_W-1:0] wd_data_i;
    logic              rd_valid_o, rd_ready_i, rd_last_o;
    logic [DATA_W-1:0] rd_data_o;
    logic              done_o, err_o, mem_we_o, mem_srst_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [DATA_W-1:0] mem_wdata_o, mem_rdata_i;
    logic [2:0]        state_o;

    int checks   = 0;
    int failures = 0;
    int done_cnt = 0;
    int err_cnt  = 0;

    logic [DATA_W-1:0]        exp_q[$];
    logic                     exp_last_q[$];
    logic [ADDR_W+DATA_W-1:0] exp_wr_q[$];
    logic [DATA_W-1:0]        shadow [DEPTH];
    logic [DATA_W-1:0]        mem_arr [DEPTH];

    mem_initiator #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .LEN_W(LEN_W)) dut (
        .clk_i(clk_i), .arst_ni(arst_ni),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_we_i(cmd_we_i),
        .cmd_addr_i(cmd_addr_i), .cmd_len_i(cmd_len_i),
        .wd_valid_i(wd_valid_i), .wd_ready_o(wd_ready_o), .wd_data_i(wd_data_i),
        .rd_valid_o(rd_valid_o), .rd_ready_i(rd_ready_i), .rd_data_o(rd_data_o),
        .rd_last_o(rd_last_o), .done_o(done_o), .err_o(err_o),
        .mem_we_o(mem_we_o), .mem_srst_o(mem_srst_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i), .state_o(state_o)
    );

    // clock / reset
    always #5 clk_i = ~clk_i;

    // single-port memory: registered read, write priority, synchronous read-data clear
    always @(posedge clk_i) begin
        if (mem_we_o)        mem_arr[mem_addr_o[9:0]] <= mem_wdata_o;
        else if (mem_srst_o) mem_rdata_i <= '0;
        else                 mem_rdata_i <= mem_arr[mem_addr_o[9:0]];
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // scoreboard / monitor
    always @(negedge clk_i) begin
        if (arst_ni) begin
            if (mem_we_o && mem_srst_o) check("we_srst_excl", 1, 0);
            if (done_o) done_cnt++;
            if (err_o)  err_cnt++;
            if (mem_we_o) begin
                if (exp_wr_q.size() == 0) check("unexpected_write", 1, 0);
                else check("mem_write", {mem_addr_o, mem_wdata_o}, exp_wr_q.pop_front());
            end
            if (rd_valid_o && rd_ready_i) begin
                if (exp_q.size() == 0) check("unexpected_read", 1, 0);
                else begin
                    check("rd_data", rd_data_o, exp_q.pop_front());
                    check("rd_last", rd_last_o, exp_last_q.pop_front());
                end
            end
        end
    end

    // driver tasks
    task automatic send_cmd(input logic we, input logic [ADDR_W-1:0] addr, input int len);
        int t;
        @(posedge clk_i); #1;
        cmd_valid_i = 1'b1; cmd_we_i = we; cmd_addr_i = addr; cmd_len_i = LEN_W'(len);
        t = 0;
        do begin @(negedge clk_i); t++; end while (!cmd_ready_o && t < 50);
        if (!cmd_ready_o) check("cmd_timeout", 0, 1);
        @(posedge clk_i); #1;
        cmd_valid_i = 1'b0;
    endtask

    task automatic do_write(input logic [ADDR_W-1:0] addr, input int len,
                            input logic [DATA_W-1:0] base, input int gap);
        int d0 = done_cnt;
        logic [9:0] ai;
        send_cmd(1'b1, addr, len);
        for (int i = 0; i <= len; i++) begin
            ai = addr[9:0] + 10'(i);
            if (i > 0) begin
                for (int g = 0; g < gap; g++) begin
                    @(negedge clk_i);
                    check("gap_no_we", mem_we_o, 0);
                    check("gap_addr", mem_addr_o, {6'b0, ai});
                    @(posedge clk_i); #1;
                end
            end
            wd_valid_i = 1'b1;
            wd_data_i  = base + DATA_W'(i);
            exp_wr_q.push_back({6'b0, ai, wd_data_i});
            shadow[ai] = wd_data_i;
            @(negedge clk_i);
            check("wd_ready", wd_ready_o, 1);
            @(posedge clk_i); #1;
            wd_valid_i = 1'b0;
        end
        repeat (2) @(negedge clk_i);
        check("wr_done_once", done_cnt, d0 + 1);
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        do begin @(negedge clk_i); lat++; end while (!rd_valid_o && lat < 10);
    endtask

    task automatic do_read(input logic [ADDR_W-1:0] addr, input int len, input int bp);
        int d0 = done_cnt;
        int lat;
        logic [9:0] ai;
        for (int i = 0; i <= len; i++) begin
            ai = addr[9:0] + 10'(i);
            exp_q.push_back(shadow[ai]);
            exp_last_q.push_back(i == len);
        end
        send_cmd(1'b0, addr, len);
        for (int i = 0; i <= len; i++) begin
            ai = addr[9:0] + 10'(i);
            wait_valid(lat);
            check("rd_latency", lat, 3);
            for (int k = 0; k < bp; k++) begin
                check("bp_valid", rd_valid_o, 1);
                check("bp_data", rd_data_o, shadow[ai]);
                check("bp_addr", mem_addr_o, {6'b0, ai});
                @(posedge clk_i); #1;
                @(negedge clk_i);
            end
            @(posedge clk_i); #1;
            rd_ready_i = 1'b1;
            @(posedge clk_i); #1;
            rd_ready_i = 1'b0;
        end
        repeat (2) @(negedge clk_i);
        check("rd_done_once", done_cnt, d0 + 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cmd_ready"}, cmd_ready_o, 1);
        check({tag, "_rd_valid"}, rd_valid_o, 0);
        check({tag, "_rd_last"}, rd_last_o, 0);
        check({tag, "_rd_data"}, rd_data_o, 0);
        check({tag, "_done"}, done_o, 0);
        check({tag, "_err"}, err_o, 0);
        check({tag, "_mem_we"}, mem_we_o, 0);
        check({tag, "_mem_srst"}, mem_srst_o, 1);
        check({tag, "_mem_addr"}, mem_addr_o, 0);
        check({tag, "_mem_wdata"}, mem_wdata_o, 0);
        check({tag, "_state"}, state_o, 0);
    endtask

    initial begin
        int lat;
        arst_ni = 1'b0; cmd_valid_i = 1'b0; cmd_we_i = 1'b0; cmd_addr_i = '0; cmd_len_i = '0;
        wd_valid_i = 1'b0; wd_data_i = '0; rd_ready_i = 1'b0;
        #1 check_reset_outputs("reset");
        repeat (3) @(posedge clk_i);
        @(negedge clk_i) arst_ni = 1'b1;

        // single write then read
        do_write(16'h005, 0, 32'hDEADBEEF, 0);
        do_read(16'h005, 0, 0);

        // read backpressure
        do_write(16'h040, 2, 32'hA0, 0);
        do_read(16'h040, 2, 5);

        // write stalls
        do_write(16'h080, 3, 32'h50, 3);
        do_read(16'h080, 3, 0);

`ifdef MEM_INITIATOR_RANGE_CHECK_EN
        begin
            int d0 = done_cnt;
            send_cmd(1'b1, 16'h3FE, 3);
            @(negedge clk_i);
            check("err_pulse", err_o, 1);
            check("err_cmd_ready", cmd_ready_o, 1);
            check("err_state_idle", state_o, 0);
            @(negedge clk_i);
            check("err_one_cycle", err_o, 0);
            repeat (3) @(negedge clk_i);
            check("err_no_done", done_cnt, d0);
            check("err_count", err_cnt, 1);
            do_write(16'h100, 0, 32'h77, 0);
            do_read(16'h100, 0, 0);
        end
`else
        // wrap across the top of memory
        do_write(16'h3FE, 3, 32'h1, 0);
        do_read(16'h3FE, 3, 1);
        check("no_err_pulses", err_cnt, 0);
`endif

        // reset during the second beat of a 4-beat read
        do_write(16'h020, 3, 32'h100, 0);
        exp_q.push_back(shadow[10'h020]);
        exp_last_q.push_back(1'b0);
        send_cmd(1'b0, 16'h020, 3);
        wait_valid(lat);
        check("rst_beat1_latency", lat, 3);
        @(posedge clk_i); #1 rd_ready_i = 1'b1;
        @(posedge clk_i); #1 rd_ready_i = 1'b0;
        wait_valid(lat);
        check("rst_beat2_valid", rd_valid_o, 1);
        @(posedge clk_i); #2 arst_ni = 1'b0;
        #1 check_reset_outputs("midburst_reset");
        @(negedge clk_i) arst_ni = 1'b1;
        @(negedge clk_i);
        check("post_reset_cmd_ready", cmd_ready_o, 1);
        do_read(16'h020, 1, 0);

        repeat (3) @(negedge clk_i);
        check("exp_q_empty", exp_q.size(), 0);
        check("exp_wr_q_empty", exp_wr_q.size(), 0);

        // final report
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        failures++;
        $display("FAIL watchdog observed=timeout expected=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule
